serial_bit_feeder: RTL

Parallel-to-serial front end for the 1011 sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on a registered `input_o`/`valid_o` pair, which drive the detector's `input_i`/`valid_i` directly. The detector has no backpressure, so each word is streamed without stalls once it starts. Back-to-back words are sent gaplessly, so patterns that straddle a word boundary are still detected.

---
 rtl/feeder_pkg.sv | 16 +
 rtl/feeder_skid_buf.sv | 47 ++++
 rtl/serial_bit_feeder.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/feeder_pkg.sv
// Shared types and helpers for the serial bit feeder.
package feeder_pkg;

    localparam int unsigned FEEDER_WIDTH_DEF = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } feeder_state_t;

    // Width of the transmit-order bit index for a given word width.
    function automatic int unsigned FEEDER_IDX_W(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/feeder_skid_buf.sv
// One-entry holding buffer that lets the next word be taken while the
// current word is still shifting out. Ready is a registered !full.
module feeder_skid_buf
    import feeder_pkg::*;
#(
    parameter int unsigned WIDTH = FEEDER_WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             ready
);

    logic [WIDTH-1:0] buf_q;
    logic             full_q;
    logic             full_d;
    logic             ready_q;

    // Occupancy after this edge; push and pop never coincide.
    always_comb begin
        full_d = (full_q & ~pop) | push;
    end

    // Buffer storage, full flag and the ready register derived from it.
    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            buf_q   <= '0;
            full_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            if (push) begin
                buf_q <= wr_data;
            end
            full_q  <= full_d;
            ready_q <= ~full_d;
        end
    end

    assign rd_data = buf_q;
    assign full    = full_q;
    assign ready   = ready_q;

endmodule

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial front end for the 1011 detector: takes WIDTH-bit
// words over valid/ready and streams them one bit per clock, gapless
// across back-to-back words. Define FEEDER_SKID_EN to add a one-entry
// holding buffer so the next word can be taken early.
module serial_bit_feeder
    import feeder_pkg::*;
#(
    parameter int unsigned WIDTH     = FEEDER_WIDTH_DEF,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                           clk_i,
    input  logic                           clr_i,
    input  logic [WIDTH-1:0]               data_i,
    input  logic                           data_valid_i,
    output logic                           data_ready_o,
    output logic                           input_o,
    output logic                           valid_o,
    output logic                           busy_o,
    output logic [FEEDER_IDX_W(WIDTH)-1:0] bit_idx_o
);

    localparam int unsigned           IDX_W    = FEEDER_IDX_W(WIDTH);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(WIDTH - 1);

    feeder_state_t    state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             valid_q, valid_d;

    logic             accept_c;
    logic             last_c;
    logic             load_c;
    logic [WIDTH-1:0] load_word_c;
    logic [WIDTH-1:0] shifted_c;

    assign accept_c = data_valid_i & data_ready_o;
    assign last_c   = (state_q == SHIFT) && (idx_q == LAST_IDX);

`ifdef FEEDER_SKID_EN
    logic             push_c;
    logic             pop_c;
    logic             buf_full;
    logic             buf_ready;
    logic [WIDTH-1:0] buf_data;

    // Mid-word accepts park in the buffer; idle or last-bit accepts go straight in.
    assign push_c      = accept_c && (state_q == SHIFT) && !last_c;
    assign pop_c       = last_c && buf_full;
    assign load_c      = (accept_c && !push_c) || pop_c;
    assign load_word_c = pop_c ? buf_data : data_i;

    feeder_skid_buf #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk_i  (clk_i),
        .clr_i  (clr_i),
        .push   (push_c),
        .pop    (pop_c),
        .wr_data(data_i),
        .rd_data(buf_data),
        .full   (buf_full),
        .ready  (buf_ready)
    );

    assign data_ready_o = buf_ready;
    assign busy_o       = (state_q == SHIFT) || buf_full;
`else
    logic alive_q;

    // Holds ready low until the first edge after reset is released.
    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            alive_q <= 1'b0;
        end else begin
            alive_q <= 1'b1;
        end
    end

    assign load_c       = accept_c;
    assign load_word_c  = data_i;
    assign data_ready_o = alive_q && ((state_q == IDLE) || last_c);
    assign busy_o       = (state_q == SHIFT);
`endif

    // Shift direction follows the configured bit order.
    always_comb begin
        if (MSB_FIRST) begin
            shifted_c = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin
            shifted_c = {1'b0, shreg_q[WIDTH-1:1]};
        end
    end

    // Next-state, counter and shift register update.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        case (state_q)
            IDLE: begin
                if (load_c) begin
                    state_d = SHIFT;
                    idx_d   = '0;
                    shreg_d = load_word_c;
                end
            end
            SHIFT: begin
                if (last_c) begin
                    idx_d = '0;
                    if (load_c) begin
                        shreg_d = load_word_c;
                    end else begin
                        state_d = IDLE;
                        shreg_d = '0;
                    end
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    shreg_d = shifted_c;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                shreg_d = '0;
            end
        endcase
        valid_d = (state_d == SHIFT);
    end

    // State and datapath registers; reset discards any word in flight.
    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            shreg_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            valid_q <= valid_d;
        end
    end

    assign input_o   = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    assign valid_o   = valid_q;
    assign bit_idx_o = idx_q;

endmodule
